// File: rtl/sig_div_seq_pkg.sv
// Shared types and sizing helpers for the
// iterative significand divider.
package sig_div_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

  localparam int N_DEF = 24;
  localparam int QW = N_DEF + 2;
  localparam int CW = $clog2(N_DEF + 2);

  function automatic int qw_of(int n);
    return n + 2;
  endfunction

  function automatic int cw_of(int n);
    return $clog2(n + 2);
  endfunction

endpackage

// File: rtl/sig_div_seq_if.sv
// Operand/result handshake bundle for the
// significand divider.
interface sig_div_seq_if #(
  parameter int N = 24
) ();

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N+1:0] q;
  logic         sticky;
  logic         dz;

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  q,
    input  sticky,
    input  dz
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output q,
    output sticky,
    output dz
  );

endinterface

// File: rtl/sig_div_seq_trial_sub.sv
// Trial subtractor x - y = x + ~y + 1 built on
// the same propagate/generate chain as the adder.
module trial_sub
  import sig_div_seq_pkg::*;
#(
  parameter int W = 25
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);

  logic [W-1:0] p;
  logic [W-1:0] g;
  logic [W:0]   c;

  // Ripple the carry through p/g; carry-in of 1
  // completes the two's-complement negation.
  always_comb begin
    p = x_i ^ ~y_i;
    g = x_i & ~y_i;
    c = '0;
    c[0] = 1'b1;
    for (int i = 0; i < W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    diff_o   = p ^ c[W-1:0];
    borrow_o = ~c[W];
  end

endmodule

// File: rtl/sig_div_seq.sv
// Restoring significand divider: one quotient bit
// per cycle, N+2 bits plus sticky for the rounder.
module sig_div_seq
  import sig_div_seq_pkg::*;
#(
  parameter int N = 24
) (
  input  logic          clk,
  input  logic          rst,
  sig_div_seq_if.slave  io
);

  localparam int QWN = qw_of(N);
  localparam int CWN = cw_of(N);

  div_state_t     state_q;
  logic [N:0]     r_q;
  logic [N-1:0]   b_q;
  logic [QWN-1:0] q_q;
  logic [CWN-1:0] cnt_q;
  logic           sticky_q;
  logic           dz_q;
  logic           ov_q;

  logic [N:0]     t_diff;
  logic           t_brw;
  logic [N:0]     r_d;
  logic [QWN-1:0] q_d;

  // Remainder stays below 2*b, so an N+1-bit
  // subtract has the same borrow as the wide one.
  trial_sub #(
    .W (N + 1)
  ) u_sub (
    .x_i      (r_q),
    .y_i      ({1'b0, b_q}),
    .diff_o   (t_diff),
    .borrow_o (t_brw)
  );

  // Restore on borrow, retire the quotient bit.
  always_comb begin
    r_d = t_brw ? r_q : t_diff;
    q_d = {q_q[QWN-2:0], ~t_brw};
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      r_q      <= '0;
      b_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      dz_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (io.in_valid) begin
            if (io.b == '0) begin
              state_q  <= DONE;
              dz_q     <= 1'b1;
              q_q      <= '1;
              sticky_q <= 1'b0;
            end else begin
              state_q <= BUSY;
              b_q     <= io.b;
              r_q     <= {1'b0, io.a};
              q_q     <= '0;
              cnt_q   <= CWN'(N + 1);
            end
          end
        end
        BUSY: begin
          q_q <= q_d;
          if (cnt_q == '0) begin
            sticky_q <= (r_d != '0);
            ov_q     <= 1'b1;
            state_q  <= DONE;
          end else begin
            r_q   <= {r_d[N-1:0], 1'b0};
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          // Zero-divisor result raises valid one
          // cycle after it is captured.
          if (!ov_q) begin
            ov_q <= 1'b1;
          end else if (io.out_ready) begin
            ov_q    <= 1'b0;
            dz_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign io.in_ready  = (state_q == IDLE) && !rst;
  assign io.out_valid = ov_q;
  assign io.q         = q_q;
  assign io.sticky    = sticky_q;
  assign io.dz        = dz_q;

endmodule

// File: tb/tb_sig_div_seq.sv
// Directed bench for sig_div_seq at N=4 and N=24
// with hand-computed quotients.
module tb_sig_div_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sig_div_seq_if #(.N(4))  if4 ();
  sig_div_seq_if #(.N(24)) if24 ();

  sig_div_seq #(.N(4)) u4 (
    .clk (clk),
    .rst (rst),
    .io  (if4)
  );

  sig_div_seq #(.N(24)) u24 (
    .clk (clk),
    .rst (rst),
    .io  (if24)
  );

  int n_chk = 0;
  int n_err = 0;

  bit          sel;
  logic        s_ov;
  logic        s_ir;
  logic        s_st;
  logic        s_dz;
  logic [63:0] s_q;

  always_comb begin
    s_ov = if4.out_valid;
    s_ir = if4.in_ready;
    s_st = if4.sticky;
    s_dz = if4.dz;
    s_q  = 64'(if4.q);
    if (sel) begin
      s_ov = if24.out_valid;
      s_ir = if24.in_ready;
      s_st = if24.sticky;
      s_dz = if24.dz;
      s_q  = 64'(if24.q);
    end
  end

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit sl, bit v,
                       logic [23:0] a, logic [23:0] b);
    if (sl) begin
      if24.in_valid = v;
      if24.a = a;
      if24.b = b;
    end else begin
      if4.in_valid = v;
      if4.a = a[3:0];
      if4.b = b[3:0];
    end
  endtask

  task automatic set_ordy(bit sl, bit r);
    if (sl) if24.out_ready = r;
    else    if4.out_ready = r;
  endtask

  task automatic run_op(string tag, bit sl,
                        logic [23:0] a, logic [23:0] b,
                        logic [63:0] eq, bit es, bit edz,
                        int elat, int bp);
    int lat;
    int w;
    bit irbad;
    sel = sl;
    set_ordy(sl, bp == 0);
    w = 0;
    while (!s_ir && w < 100) begin
      step();
      w++;
    end
    check({tag, " ready"}, 64'(s_ir), 64'd1);
    drive(sl, 1'b1, a, b);
    step();
    drive(sl, 1'b0, '0, '0);
    lat = 0;
    irbad = 1'b0;
    while (!s_ov && lat < 200) begin
      if (s_ir) irbad = 1'b1;
      step();
      lat++;
    end
    if (s_ir) irbad = 1'b1;
    check({tag, " lat"}, 64'(lat), 64'(elat));
    check({tag, " q"}, s_q, eq);
    check({tag, " sticky"}, 64'(s_st), 64'(es));
    check({tag, " dz"}, 64'(s_dz), 64'(edz));
    check({tag, " busy_rdy"}, 64'(irbad), 64'd0);
    for (int i = 0; i < bp; i++) begin
      step();
      check({tag, " bp_ov"}, 64'(s_ov), 64'd1);
      check({tag, " bp_q"}, s_q, eq);
      check({tag, " bp_st"}, 64'(s_st), 64'(es));
      check({tag, " bp_rdy"}, 64'(s_ir), 64'd0);
    end
    set_ordy(sl, 1'b1);
    step();
    check({tag, " post_ov"}, 64'(s_ov), 64'd0);
    check({tag, " post_dz"}, 64'(s_dz), 64'd0);
    check({tag, " post_rdy"}, 64'(s_ir), 64'd1);
    check({tag, " post_q"}, s_q, eq);
  endtask

  initial begin
    sel = 1'b0;
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
    set_ordy(1'b0, 1'b1);
    set_ordy(1'b1, 1'b1);
    step();
    step();
    check("rst_ov", 64'(s_ov), 64'd0);
    check("rst_q", s_q, 64'd0);
    check("rst_st", 64'(s_st), 64'd0);
    check("rst_dz", 64'(s_dz), 64'd0);
    check("rst_rdy", 64'(s_ir), 64'd0);
    rst = 1'b0;
    #1;
    check("rel_rdy", 64'(s_ir), 64'd1);

    run_op("n4_8_8",   1'b0, 24'd8,  24'd8,
           64'd32, 1'b0, 1'b0, 6, 0);
    run_op("n4_15_8",  1'b0, 24'd15, 24'd8,
           64'd60, 1'b0, 1'b0, 6, 0);
    run_op("n4_8_12",  1'b0, 24'd8,  24'd12,
           64'd21, 1'b1, 1'b0, 6, 0);
    run_op("n4_15_9",  1'b0, 24'd15, 24'd9,
           64'd53, 1'b1, 1'b0, 6, 0);
    run_op("n4_dz",    1'b0, 24'd9,  24'd0,
           64'h3f, 1'b0, 1'b1, 1, 0);
    run_op("n4_bp",    1'b0, 24'd15, 24'd8,
           64'd60, 1'b0, 1'b0, 6, 5);
    run_op("n24_eq",   1'b1, 24'h800000, 24'h800000,
           64'h2000000, 1'b0, 1'b0, 26, 0);
    run_op("n24_max",  1'b1, 24'hffffff, 24'h800000,
           64'h3fffffc, 1'b0, 1'b0, 26, 0);

    sel = 1'b0;
    drive(1'b0, 1'b1, 24'd15, 24'd9);
    step();
    drive(1'b0, 1'b0, '0, '0);
    step();
    step();
    rst = 1'b1;
    step();
    check("mid_ov", 64'(s_ov), 64'd0);
    check("mid_q", s_q, 64'd0);
    check("mid_rdy", 64'(s_ir), 64'd0);
    rst = 1'b0;
    #1;
    check("mid_rel_rdy", 64'(s_ir), 64'd1);
    run_op("n4_after", 1'b0, 24'd8, 24'd12,
           64'd21, 1'b1, 1'b0, 6, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
